// File: rtl/magic_ctrl_pkg.sv
// Shared types and constants for the magic/NMI controller and its config register consumers.
package magic_ctrl_pkg;

  localparam int unsigned ADDR_W    = 16;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned IDX_W     = 8;
  localparam int unsigned NMI_CNT_W = 20;

  localparam int unsigned MAGIC_IDX_STATUS  = 0;
  localparam int unsigned MAGIC_IDX_MACHINE = 2;
  localparam int unsigned MAGIC_IDX_TURBO   = 3;

  typedef enum logic [2:0] {
    IDLE,
    PEND,
    MAPPED,
    UNMAP,
    UNMAP_RET,
    REMAP
  } magic_state_t;

endpackage

// File: rtl/magic_ctrl_if.sv
// CPU bus view shared by the magic controller: address, write data and strobes.
interface magic_ctrl_if;
  import magic_ctrl_pkg::*;

  logic [ADDR_W-1:0] a;
  logic [DATA_W-1:0] d;
  logic              rd;
  logic              wr;
  logic              memreq;
  logic              memreq_rise;
  logic              ioreq;
  logic              m1;

  modport master (output a, d, rd, wr, memreq, memreq_rise, ioreq, m1);
  modport slave  (input  a, d, rd, wr, memreq, memreq_rise, ioreq, m1);
endinterface

// File: rtl/magic_cfg_regs.sv
// Config register file: indices 1..NREGS-1 writable, slot 0 reads as zero.
module magic_cfg_regs
  import magic_ctrl_pkg::*;
#(
  parameter int unsigned            NREGS     = 16,
  parameter logic [8*NREGS-1:0]     CFG_RESET = '0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_wr_en,
  input  logic [IDX_W-1:0]          i_idx,
  input  logic [DATA_W-1:0]         i_wdata,
  output logic [DATA_W-1:0]         o_rdata_c,
  output logic [8*NREGS-1:0]        o_cfg
);

  logic [DATA_W-1:0] r_cfg [1:NREGS-1];

  // Out-of-range and status indices match no entry, so they are ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < int'(NREGS); i++) r_cfg[i] <= CFG_RESET[8*i +: 8];
    end else if (i_wr_en) begin
      for (int i = 1; i < int'(NREGS); i++) begin
        if (i_idx == IDX_W'(i)) r_cfg[i] <= i_wdata;
      end
    end
  end

  always_comb begin
    o_rdata_c = '0;
    for (int i = 1; i < int'(NREGS); i++) begin
      if (i_idx == IDX_W'(i)) o_rdata_c = r_cfg[i];
    end
  end

  always_comb begin
    o_cfg = '0;
    for (int i = 1; i < int'(NREGS); i++) o_cfg[8*i +: 8] = r_cfg[i];
  end

endmodule

// File: rtl/magic_ctrl.sv
// Magic/NMI controller: trigger arbitration, magic ROM mapping FSM and config port readback.
// Optional NMI watchdog enabled by defining MAGIC_NMI_TIMEOUT_EN.
module magic_ctrl
  import magic_ctrl_pkg::*;
#(
`ifdef MAGIC_NMI_TIMEOUT_EN
  parameter logic [NMI_CNT_W-1:0] NMI_TIMEOUT = 20'd700000,
`endif
  parameter int unsigned          NSRC        = 2,
  parameter int unsigned          NREGS       = 16,
  parameter logic [7:0]           CFG_PORT    = 8'hFF,
  parameter logic [ADDR_W-1:0]    ENTRY_ADDR  = 16'h0066,
  parameter logic [ADDR_W-1:0]    EXIT_ADDR   = 16'hF000,
  parameter logic [ADDR_W-1:0]    RETURN_ADDR = 16'hF008,
  parameter logic [8*NREGS-1:0]   CFG_RESET   = '0
) (
  input  logic                clk28,
  input  logic                rst_n,
  magic_ctrl_if.slave         bus,
  input  logic [NSRC-1:0]     trig,
  input  logic                n_int,
  input  logic                n_int_next,
  input  logic                div_paged,
  output logic [DATA_W-1:0]   d_out,
  output logic                d_out_active,
  output logic                n_nmi,
  output logic                magic_mode,
  output logic                magic_map,
  output logic [8*NREGS-1:0]  cfg
);

  magic_state_t      r_state, w_state_nxt;
  logic              r_n_nmi, r_magic_mode, r_magic_map;
  logic              w_n_nmi_nxt, w_magic_mode_nxt, w_magic_map_nxt;
  logic [NSRC-1:0]   r_cause, w_cause_nxt;
  logic [DATA_W-1:0] r_d_out;
  logic              r_d_out_active;

  logic              w_strobe, w_entry, w_any_fetch, w_exit_rd, w_ret_rd;
  logic              w_timeout, w_to_flag;
  logic              w_cs, w_idx_ok, w_rd_hit, w_wr_en;
  logic [IDX_W-1:0]  w_idx;
  logic [DATA_W-1:0] w_status, w_cfg_rdata;

  assign w_strobe    = (|trig) && n_int && !n_int_next;
  assign w_any_fetch = bus.m1 && bus.memreq_rise;
  assign w_entry     = w_any_fetch && (bus.a == ENTRY_ADDR);
  assign w_exit_rd   = bus.memreq && bus.rd && (bus.a == EXIT_ADDR);
  assign w_ret_rd    = bus.memreq && bus.rd && (bus.a == RETURN_ADDR);

  assign w_idx    = bus.a[15:8];
  assign w_idx_ok = (9'(w_idx) < 9'(NREGS));
  assign w_cs     = r_magic_map && bus.ioreq && (bus.a[7:0] == CFG_PORT);
  assign w_rd_hit = w_cs && bus.rd && w_idx_ok;
  assign w_wr_en  = w_cs && bus.wr;
  assign w_status = {w_to_flag, 3'(r_cause), div_paged, 1'b1, 2'(trig)};

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= MAPPED;
      r_n_nmi      <= 1'b1;
      r_magic_mode <= 1'b1;
      r_magic_map  <= 1'b1;
      r_cause      <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_n_nmi      <= w_n_nmi_nxt;
      r_magic_mode <= w_magic_mode_nxt;
      r_magic_map  <= w_magic_map_nxt;
      r_cause      <= w_cause_nxt;
    end
  end

  // Return read takes priority over exit read in MAPPED
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:      if (w_strobe) w_state_nxt = PEND;
      PEND: begin
        if (w_entry)        w_state_nxt = MAPPED;
        else if (w_timeout) w_state_nxt = IDLE;
      end
      MAPPED: begin
        if (w_ret_rd)       w_state_nxt = UNMAP_RET;
        else if (w_exit_rd) w_state_nxt = UNMAP;
      end
      UNMAP:     if (!bus.memreq) w_state_nxt = IDLE;
      UNMAP_RET: if (!bus.memreq) w_state_nxt = REMAP;
      REMAP:     if (w_any_fetch) w_state_nxt = MAPPED;
      default:   w_state_nxt = MAPPED;
    endcase
  end

  always_comb begin
    w_n_nmi_nxt      = r_n_nmi;
    w_magic_mode_nxt = r_magic_mode;
    w_magic_map_nxt  = r_magic_map;
    w_cause_nxt      = r_cause;
    case (r_state)
      IDLE: if (w_strobe) begin
        w_n_nmi_nxt      = 1'b0;
        w_magic_mode_nxt = 1'b1;
        w_cause_nxt      = trig;
      end
      PEND: begin
        if (w_entry) begin
          w_n_nmi_nxt     = 1'b1;
          w_magic_map_nxt = 1'b1;
        end else if (w_timeout) begin
          w_n_nmi_nxt      = 1'b1;
          w_magic_mode_nxt = 1'b0;
        end
      end
      MAPPED:    if (!w_ret_rd && w_exit_rd) w_magic_mode_nxt = 1'b0;
      UNMAP,
      UNMAP_RET: if (!bus.memreq) w_magic_map_nxt = 1'b0;
      REMAP:     if (w_any_fetch) w_magic_map_nxt = 1'b1;
      default: ;
    endcase
  end

`ifdef MAGIC_NMI_TIMEOUT_EN
  logic [NMI_CNT_W-1:0] r_to_cnt;
  logic                 r_to_flag, r_rd_status, w_rd_status;

  assign w_rd_status = w_rd_hit && (w_idx == IDX_W'(MAGIC_IDX_STATUS));
  assign w_timeout   = (r_state == PEND) && (r_to_cnt == NMI_TIMEOUT - NMI_CNT_W'(1));
  assign w_to_flag   = r_to_flag;

  // Counter counts PEND cycles; to_flag clears once a status read completes
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt    <= '0;
      r_to_flag   <= 1'b0;
      r_rd_status <= 1'b0;
    end else begin
      r_to_cnt    <= ((r_state == PEND) && (w_state_nxt == PEND)) ? r_to_cnt + NMI_CNT_W'(1) : '0;
      r_rd_status <= w_rd_status;
      if (!w_entry && w_timeout)            r_to_flag <= 1'b1;
      else if (r_rd_status && !w_rd_status) r_to_flag <= 1'b0;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign w_to_flag = 1'b0;
`endif

  magic_cfg_regs #(
    .NREGS     (NREGS),
    .CFG_RESET (CFG_RESET)
  ) u_cfg_regs (
    .clk       (clk28),
    .rst_n     (rst_n),
    .i_wr_en   (w_wr_en),
    .i_idx     (w_idx),
    .i_wdata   (bus.d),
    .o_rdata_c (w_cfg_rdata),
    .o_cfg     (cfg)
  );

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      r_d_out_active <= 1'b0;
      r_d_out        <= '0;
    end else begin
      r_d_out_active <= w_rd_hit;
      r_d_out        <= !w_rd_hit ? '0 :
                        (w_idx == IDX_W'(MAGIC_IDX_STATUS)) ? w_status : w_cfg_rdata;
    end
  end

  assign d_out        = r_d_out;
  assign d_out_active = r_d_out_active;
  assign n_nmi        = r_n_nmi;
  assign magic_mode   = r_magic_mode;
  assign magic_map    = r_magic_map;

endmodule

// File: tb/tb_magic_ctrl.sv
// Randomized bench for magic_ctrl against a transaction-level session model.
module tb_magic_ctrl;
  localparam int unsigned NREGS = 16;
  localparam logic [15:0] ENTRY = 16'h0066;
  localparam logic [15:0] EXITA = 16'hF000;
  localparam logic [15:0] RETA  = 16'hF008;

  logic clk28 = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] trig;
  logic n_int, n_int_next, div_paged;
  logic [7:0] d_out;
  logic d_out_active, n_nmi, magic_mode, magic_map;
  logic [8*NREGS-1:0] cfg;

  magic_ctrl_if bus();

  magic_ctrl #(
`ifdef MAGIC_NMI_TIMEOUT_EN
    .NMI_TIMEOUT (20'd100),
`endif
    .NSRC  (2),
    .NREGS (NREGS)
  ) dut (
    .clk28        (clk28),
    .rst_n        (rst_n),
    .bus          (bus),
    .trig         (trig),
    .n_int        (n_int),
    .n_int_next   (n_int_next),
    .div_paged    (div_paged),
    .d_out        (d_out),
    .d_out_active (d_out_active),
    .n_nmi        (n_nmi),
    .magic_mode   (magic_mode),
    .magic_map    (magic_map),
    .cfg          (cfg)
  );

  initial forever #5 clk28 = ~clk28;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Session model: 0 = unmapped/idle, 1 = NMI pending, 2 = mapped, 3 = awaiting remap fetch
  int         phase;
  logic [1:0] m_cause;
  logic       m_to_flag;
  logic [7:0] m_cfg [NREGS];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] model_cfg();
    logic [127:0] v = '0;
    for (int i = 1; i < int'(NREGS); i++) v[8*i +: 8] = m_cfg[i];
    return v;
  endfunction

  task automatic tick();
    @(posedge clk28);
    #1;
  endtask

  task automatic model_reset();
    phase     = 2;
    m_cause   = 2'b00;
    m_to_flag = 1'b0;
    for (int i = 0; i < int'(NREGS); i++) m_cfg[i] = 8'h00;
  endtask

  task automatic bus_idle();
    bus.a = '0; bus.d = '0; bus.rd = 0; bus.wr = 0;
    bus.memreq = 0; bus.memreq_rise = 0; bus.ioreq = 0; bus.m1 = 0;
    trig = 2'b00; n_int = 1; n_int_next = 1; div_paged = 0;
  endtask

  task automatic check_ctrl(input string tag);
    check({tag, "_nmi"},  n_nmi,      (phase != 1));
    check({tag, "_mode"}, magic_mode, (phase != 0));
    check({tag, "_map"},  magic_map,  (phase == 2));
  endtask

  task automatic check_reset_outputs();
    check("rst_nmi", n_nmi, 1'b1);
    check("rst_mode", magic_mode, 1'b1);
    check("rst_map", magic_map, 1'b1);
    check("rst_act", d_out_active, 1'b0);
    check("rst_dout", d_out, 8'h00);
    check("rst_cfg", cfg, model_cfg());
  endtask

  task automatic frame(input logic [1:0] t);
    trig = t; n_int = 1; n_int_next = 0;
    tick();
    trig = 2'b00; n_int_next = 1;
    tick();
    if (phase == 0 && t != 2'b00) begin
      phase   = 1;
      m_cause = t;
    end
    check_ctrl("frame");
  endtask

  task automatic fetch(input logic [15:0] addr);
    bus.m1 = 1; bus.memreq = 1; bus.memreq_rise = 1; bus.rd = 1; bus.a = addr;
    tick();
    bus.memreq_rise = 0;
    tick();
    bus.m1 = 0; bus.memreq = 0; bus.rd = 0;
    tick();
    if ((phase == 1 && addr == ENTRY) || phase == 3) phase = 2;
    check_ctrl("fetch");
  endtask

  task automatic mem_read(input logic [15:0] addr);
    bit ex, rt;
    ex = (phase == 2) && (addr == EXITA);
    rt = (phase == 2) && (addr == RETA);
    bus.memreq = 1; bus.memreq_rise = 1; bus.rd = 1; bus.a = addr;
    tick();
    bus.memreq_rise = 0;
    check("rd_mode_early", magic_mode, ex ? 1'b0 : (phase != 0));
    check("rd_map_held", magic_map, (phase == 2));
    tick();
    bus.memreq = 0; bus.rd = 0;
    tick();
    if (ex) phase = 0;
    if (rt) phase = 3;
    check_ctrl("memrd");
  endtask

  task automatic io_write(input logic [7:0] idx, input logic [7:0] data, input logic [7:0] port);
    bus.a = {idx, port}; bus.d = data; bus.ioreq = 1; bus.wr = 1;
    tick();
    tick();
    bus.ioreq = 0; bus.wr = 0;
    tick();
    if (phase == 2 && port == 8'hFF && idx >= 8'd1 && idx < 8'(NREGS)) m_cfg[idx] = data;
    check("cfg", cfg, model_cfg());
  endtask

  task automatic io_read(input logic [7:0] idx, input logic [7:0] port,
                         input logic [1:0] t, input logic dp);
    bit         act;
    logic [7:0] exp_d;
    trig = t; div_paged = dp;
    bus.a = {idx, port}; bus.ioreq = 1; bus.rd = 1;
    tick();
    act   = (phase == 2) && (port == 8'hFF) && (idx < 8'(NREGS));
    exp_d = !act ? 8'h00 :
            (idx == 8'd0) ? {m_to_flag, 1'b0, m_cause, dp, 1'b1, t} : m_cfg[idx];
    check("rd_act", d_out_active, act);
    check("rd_data", d_out, exp_d);
    bus.ioreq = 0; bus.rd = 0; trig = 2'b00;
    tick();
    check("rd_act_drop", d_out_active, 1'b0);
    check("rd_data_drop", d_out, 8'h00);
    if (act && idx == 8'd0) m_to_flag = 1'b0;
  endtask

  function automatic logic [15:0] rand_addr();
    logic [15:0] v = 16'($urandom);
    if (v == EXITA || v == RETA) v = 16'h1234;
    return v;
  endfunction

  task automatic mid_reset();
    bus.memreq = 1; bus.rd = 1; bus.a = rand_addr();
    #3;
    rst_n = 0;
    #1;
    model_reset();
    check_reset_outputs();
    bus_idle();
    tick();
    rst_n = 1;
    tick();
    check_ctrl("post_rst");
  endtask

  initial begin
    bus_idle();
    model_reset();
    repeat (2) @(posedge clk28);
    #1;
    check_reset_outputs();
    rst_n = 1;
    tick();

    io_read(8'd0, 8'hFF, 2'b00, 1'b0);
    check("status_idle", d_out_active, 1'b0);
    io_write(8'd5, 8'hA5, 8'hFF);
    io_read(8'd5, 8'hFF, 2'b00, 1'b0);
    io_write(8'd0, 8'h3C, 8'hFF);
    io_read(8'd16, 8'hFF, 2'b00, 1'b0);
    mem_read(EXITA);
    io_write(8'd3, 8'h5A, 8'hFF);
    io_read(8'd3, 8'hFF, 2'b00, 1'b0);
    frame(2'b01);
    frame(2'b10);
    fetch(ENTRY);
    io_read(8'd0, 8'hFF, 2'b00, 1'b1);
    mem_read(RETA);
    fetch(16'h8000);

`ifdef MAGIC_NMI_TIMEOUT_EN
    begin
      int cnt = 0;
      mem_read(EXITA);
      trig = 2'b01; n_int = 1; n_int_next = 0;
      tick();
      trig = 2'b00; n_int_next = 1;
      check("to_nmi_low", n_nmi, 1'b0);
      while (n_nmi == 1'b0 && cnt < 200) begin
        tick();
        cnt++;
      end
      check("to_cycles", 32'(cnt), 32'd100);
      phase = 0; m_cause = 2'b01; m_to_flag = 1'b1;
      check_ctrl("to_end");
      frame(2'b10);
      fetch(ENTRY);
      io_read(8'd0, 8'hFF, 2'b00, 1'b0);
      io_read(8'd0, 8'hFF, 2'b00, 1'b0);
    end
`else
    for (int i = 0; i < 400; i++) begin
      logic [7:0] port;
      port = ($urandom_range(0, 3) == 0) ? 8'hFE : 8'hFF;
      if (i == 200) mid_reset();
      case ($urandom_range(0, 5))
        0: frame(2'($urandom_range(0, 3)));
        1: fetch($urandom_range(0, 1) ? ENTRY : rand_addr());
        2: begin
          case ($urandom_range(0, 2))
            0:       mem_read(EXITA);
            1:       mem_read(RETA);
            default: mem_read(rand_addr());
          endcase
        end
        3: io_write(8'($urandom_range(0, 17)), 8'($urandom), port);
        default: io_read(8'($urandom_range(0, 17)), port, 2'($urandom), 1'($urandom));
      endcase
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
